lsu_issue_buffer: RTL and testbench

- Parametrised LSU front-end buffer between issue/ID and the load/store memory unit.
- Accepts operand bundles with a valid/ready handshake, computes the effective address (operand_a + imm), and flags misalignment.
- Queues up to DEPTH requests in order; loads leave immediately, stores are held until committed.
- Successor to the fixed 64-bit, single-outstanding LSU port: adds width/depth parametrisation, multiple outstanding requests and commit gating.

---
 rtl/lsu_issue_buffer.sv | 136 +++++++++++++
 tb/tb_lsu_issue_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_issue_buffer.sv
// In-order LSU issue buffer: computes effective address and misalignment at push,
// releases loads immediately and holds stores at the head until committed.
module lsu_issue_buffer #(
    parameter int OPERAND_SIZE  = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter int DEPTH         = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_store_i,
    input  logic [1:0]                 req_size_i,
    input  logic [OPERAND_SIZE-1:0]    operand_a_i,
    input  logic [OPERAND_SIZE-1:0]    operand_b_i,
    input  logic [OPERAND_SIZE-1:0]    imm_i,
    input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
    input  logic                       commit_i,
    output logic                       mem_valid_o,
    input  logic                       mem_ready_i,
    output logic [OPERAND_SIZE-1:0]    mem_addr_o,
    output logic [OPERAND_SIZE-1:0]    mem_wdata_o,
    output logic                       mem_store_o,
    output logic [1:0]                 mem_size_o,
    output logic [TRANS_ID_BITS-1:0]   mem_trans_id_o,
    output logic                       mem_misaligned_o,
    output logic [$clog2(DEPTH+1)-1:0] usage_o,
    output logic [$clog2(DEPTH+1)-1:0] commit_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [OPERAND_SIZE-1:0]  addr_q  [DEPTH];
    logic [OPERAND_SIZE-1:0]  wdata_q [DEPTH];
    logic                     store_q [DEPTH];
    logic [1:0]               size_q  [DEPTH];
    logic [TRANS_ID_BITS-1:0] id_q    [DEPTH];
    logic                     mis_q   [DEPTH];

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] usage_q, commit_q, store_cnt_q;

    logic [OPERAND_SIZE-1:0] eff_addr;
    logic                    misaligned;
    logic                    push, pop, pop_store;

    assign eff_addr = operand_a_i + imm_i;

    always_comb begin
        misaligned = 1'b0;
        case (req_size_i)
            2'd1:    misaligned = eff_addr[0];
            2'd2:    misaligned = |eff_addr[1:0];
            2'd3:    misaligned = |eff_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Both ports are valid/ready: a beat transfers on the edge where valid && ready,
    // valid never depends on ready, and the offered payload is held until it transfers.
    assign req_ready_o = (usage_q != FULL);
    assign mem_valid_o = (usage_q != '0) && (!store_q[head_q] || (commit_q != '0));

    assign push      = req_valid_i && req_ready_o && !flush_i;
    assign pop       = mem_valid_o && mem_ready_i && !flush_i;
    assign pop_store = pop && store_q[head_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_q[tail_q]  <= eff_addr;
            wdata_q[tail_q] <= operand_b_i;
            store_q[tail_q] <= req_store_i;
            size_q[tail_q]  <= req_size_i;
            id_q[tail_q]    <= trans_id_i;
            mis_q[tail_q]   <= misaligned;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q      <= '0;
            tail_q      <= '0;
            usage_q     <= '0;
            store_cnt_q <= '0;
        end else if (flush_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            usage_q     <= '0;
            store_cnt_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            case ({push, pop})
                2'b10:   usage_q <= usage_q + CW'(1);
                2'b01:   usage_q <= usage_q - CW'(1);
                default: usage_q <= usage_q;
            endcase
            case ({push && req_store_i, pop_store})
                2'b10:   store_cnt_q <= store_cnt_q + CW'(1);
                2'b01:   store_cnt_q <= store_cnt_q - CW'(1);
                default: store_cnt_q <= store_cnt_q;
            endcase
        end
    end

    // Commit credits survive a flush: committed stores are architecturally owed to memory.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            commit_q <= '0;
        end else begin
            case ({commit_i, pop_store})
                2'b10:   commit_q <= commit_q + CW'(1);
                2'b01:   commit_q <= commit_q - CW'(1);
                default: commit_q <= commit_q;
            endcase
        end
    end

    assign mem_addr_o       = addr_q[head_q];
    assign mem_wdata_o      = wdata_q[head_q];
    assign mem_store_o      = store_q[head_q];
    assign mem_size_o       = size_q[head_q];
    assign mem_trans_id_o   = id_q[head_q];
    assign mem_misaligned_o = mis_q[head_q];
    assign usage_o          = usage_q;
    assign commit_cnt_o     = commit_q;

    a_commit_has_store: assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_i |-> (commit_q != store_cnt_q));
    a_flush_no_commit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_i |-> (commit_q == '0));

endmodule

// File: tb/tb_lsu_issue_buffer.sv
// Directed bench for lsu_issue_buffer: a push-side scoreboard queue checked by a
// negedge monitor on every downstream handshake, plus directed status checks.
module tb_lsu_issue_buffer;

    localparam int IW = 64 + 64 + 1 + 2 + 3 + 1;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_store_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic [63:0] operand_a_i = '0;
    logic [63:0] operand_b_i = '0;
    logic [63:0] imm_i = '0;
    logic [2:0]  trans_id_i = '0;
    logic        commit_i = 1'b0;
    logic        mem_valid_o;
    logic        mem_ready_i = 1'b0;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic        mem_store_o;
    logic [1:0]  mem_size_o;
    logic [2:0]  mem_trans_id_o;
    logic        mem_misaligned_o;
    logic [2:0]  usage_o;
    logic [2:0]  commit_cnt_o;

    logic [IW-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    lsu_issue_buffer #(.OPERAND_SIZE(64), .TRANS_ID_BITS(3), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_store_i(req_store_i), .req_size_i(req_size_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .imm_i(imm_i),
        .trans_id_i(trans_id_i), .commit_i(commit_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_store_o(mem_store_o), .mem_size_o(mem_size_o),
        .mem_trans_id_o(mem_trans_id_o), .mem_misaligned_o(mem_misaligned_o),
        .usage_o(usage_o), .commit_cnt_o(commit_cnt_o)
    );

    // clock / reset block
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver: one push per call, expected head image queued with it
    task automatic push(input logic st, input logic [1:0] sz, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] im, input logic [2:0] id,
                        input logic [63:0] exp_addr, input logic exp_mis);
        check("push_ready", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1;
        req_store_i = st;
        req_size_i  = sz;
        operand_a_i = a;
        operand_b_i = b;
        imm_i       = im;
        trans_id_i  = id;
        exp_q.push_back({exp_addr, (st ? b : 64'd0), st, sz, id, exp_mis});
        step();
        req_valid_i = 1'b0;
    endtask

    // monitor: compare every downstream transfer against the scoreboard head
    always @(negedge clk_i) begin
        if (rst_ni && !flush_i && mem_valid_o && mem_ready_i) begin
            logic [IW-1:0] act;
            logic [IW-1:0] exp;
            act = {mem_addr_o, (mem_store_o ? mem_wdata_o : 64'd0), mem_store_o,
                   mem_size_o, mem_trans_id_o, mem_misaligned_o};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL pop_data actual=%0h required=%0h", act, exp);
                end
            end
        end
    end

    initial begin
        step();
        step();
        rst_ni = 1'b1;
        step();
        check("reset_ready", {63'd0, req_ready_o}, 64'd1);
        check("reset_usage", {61'd0, usage_o}, 64'd0);
        check("reset_valid", {63'd0, mem_valid_o}, 64'd0);
        check("reset_commit", {61'd0, commit_cnt_o}, 64'd0);

        // 1. load pass-through
        mem_ready_i = 1'b1;
        push(1'b0, 2'd3, 64'h1000, 64'h0, 64'h8, 3'd2, 64'h1008, 1'b0);
        check("t1_valid", {63'd0, mem_valid_o}, 64'd1);
        check("t1_usage", {61'd0, usage_o}, 64'd1);
        step();
        check("t1_drained", {61'd0, usage_o}, 64'd0);

        // 2. store gating until commit
        push(1'b1, 2'd3, 64'h2000, 64'hDEAD, 64'h0, 3'd1, 64'h2000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t2_gated", {63'd0, mem_valid_o}, 64'd0);
            step();
        end
        commit_i = 1'b1;
        check("t2_same_cycle", {63'd0, mem_valid_o}, 64'd0);
        step();
        commit_i = 1'b0;
        check("t2_released", {63'd0, mem_valid_o}, 64'd1);
        check("t2_cnt1", {61'd0, commit_cnt_o}, 64'd1);
        step();
        check("t2_cnt0", {61'd0, commit_cnt_o}, 64'd0);
        check("t2_usage", {61'd0, usage_o}, 64'd0);

        // 3. full / backpressure
        mem_ready_i = 1'b0;
        push(1'b0, 2'd3, 64'h3000, 64'h0, 64'h0, 3'd0, 64'h3000, 1'b0);
        push(1'b0, 2'd3, 64'h3008, 64'h0, 64'h0, 3'd1, 64'h3008, 1'b0);
        push(1'b0, 2'd3, 64'h3010, 64'h0, 64'h0, 3'd2, 64'h3010, 1'b0);
        push(1'b0, 2'd3, 64'h3018, 64'h0, 64'h0, 3'd3, 64'h3018, 1'b0);
        check("t3_full_ready", {63'd0, req_ready_o}, 64'd0);
        check("t3_full_usage", {61'd0, usage_o}, 64'd4);
        step();
        check("t3_hold_usage", {61'd0, usage_o}, 64'd4);
        mem_ready_i = 1'b1;
        step();
        check("t3_ready_back", {63'd0, req_ready_o}, 64'd1);
        check("t3_usage3", {61'd0, usage_o}, 64'd3);
        step();
        step();
        step();
        check("t3_drained", {61'd0, usage_o}, 64'd0);

        // 4. wrap with simultaneous push/pop
        for (int i = 0; i < 10; i++) begin
            push(1'b0, 2'd2, 64'h4000 + 64'(i) * 64'h10, 64'h0, 64'h4, 3'(i),
                 64'h4004 + 64'(i) * 64'h10, 1'b0);
            check("t4_usage", {61'd0, usage_o}, 64'd1);
        end
        step();
        check("t4_drained", {61'd0, usage_o}, 64'd0);

        // 4b. commit coincident with a store pop
        mem_ready_i = 1'b0;
        push(1'b1, 2'd3, 64'h5000, 64'hA5A5, 64'h0, 3'd5, 64'h5000, 1'b0);
        push(1'b1, 2'd3, 64'h5008, 64'h5A5A, 64'h0, 3'd6, 64'h5008, 1'b0);
        commit_i = 1'b1;
        step();
        check("t4b_valid", {63'd0, mem_valid_o}, 64'd1);
        mem_ready_i = 1'b1;
        step();
        commit_i = 1'b0;
        check("t4b_cnt_hold", {61'd0, commit_cnt_o}, 64'd1);
        check("t4b_usage1", {61'd0, usage_o}, 64'd1);
        step();
        check("t4b_cnt0", {61'd0, commit_cnt_o}, 64'd0);
        check("t4b_usage0", {61'd0, usage_o}, 64'd0);

        // 5. misalignment and address wrap
        push(1'b0, 2'd2, 64'h1002, 64'h0, 64'h0, 3'd0, 64'h1002, 1'b1);
        push(1'b0, 2'd1, 64'h1000, 64'h0, 64'h3, 3'd1, 64'h1003, 1'b1);
        push(1'b0, 2'd0, 64'h1003, 64'h0, 64'h0, 3'd2, 64'h1003, 1'b0);
        push(1'b0, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h10, 3'd3, 64'h8, 1'b0);
        push(1'b0, 2'd3, 64'h1004, 64'h0, 64'h0, 3'd4, 64'h1004, 1'b1);
        push(1'b0, 2'd1, 64'h1002, 64'h0, 64'h0, 3'd5, 64'h1002, 1'b0);
        step();
        check("t5_drained", {61'd0, usage_o}, 64'd0);

        // 6. flush with three loads queued; push and pop in the flush cycle are ignored
        mem_ready_i = 1'b0;
        push(1'b0, 2'd3, 64'h6000, 64'h0, 64'h0, 3'd0, 64'h6000, 1'b0);
        push(1'b0, 2'd3, 64'h6008, 64'h0, 64'h0, 3'd1, 64'h6008, 1'b0);
        push(1'b0, 2'd3, 64'h6010, 64'h0, 64'h0, 3'd2, 64'h6010, 1'b0);
        check("t6_usage3", {61'd0, usage_o}, 64'd3);
        flush_i     = 1'b1;
        mem_ready_i = 1'b1;
        req_valid_i = 1'b1;
        operand_a_i = 64'h6018;
        step();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        exp_q.delete();
        check("t6_flush_usage", {61'd0, usage_o}, 64'd0);
        check("t6_flush_valid", {63'd0, mem_valid_o}, 64'd0);

        // 6b. reset mid-stream with two committed stores
        mem_ready_i = 1'b0;
        push(1'b1, 2'd3, 64'h7000, 64'h11, 64'h0, 3'd1, 64'h7000, 1'b0);
        push(1'b1, 2'd3, 64'h7008, 64'h22, 64'h0, 3'd2, 64'h7008, 1'b0);
        commit_i = 1'b1;
        step();
        step();
        commit_i = 1'b0;
        check("t6_commit2", {61'd0, commit_cnt_o}, 64'd2);
        rst_ni = 1'b0;
        step();
        exp_q.delete();
        check("t6_rst_usage", {61'd0, usage_o}, 64'd0);
        check("t6_rst_commit", {61'd0, commit_cnt_o}, 64'd0);
        check("t6_rst_valid", {63'd0, mem_valid_o}, 64'd0);
        rst_ni = 1'b1;
        step();
        check("t6_rst_ready", {63'd0, req_ready_o}, 64'd1);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
